// File: rtl/psum_drain_pkg.sv
// rtl/psum_drain_pkg.sv - PE array configuration constants and drain types
// Purpose: shared widths of the PE column (PEROW lanes, PSUMDWD-bit psums,
//          DWD-bit quantized words) plus the per-vector drain configuration.
// Ports:   none (package).
package psum_drain_pkg;

  localparam int PEROW     = 16;
  localparam int DWD       = 8;
  localparam int PSUMDWD   = 16;
  localparam int DRSHIFTWD = 5;

  typedef struct packed {
    logic                 relu_en;
    logic [DRSHIFTWD-1:0] shift;
  } DRconf;

  typedef enum logic {
    DR_IDLE = 1'b0,
    DR_SEND = 1'b1
  } dr_state_e;

endpackage

// File: rtl/psum_drain_if.sv
// rtl/psum_drain_if.sv - POUT input and global-buffer output handshakes of psum_drain
// Purpose: bundles the upstream psum vector handshake and the downstream beat
//          handshake. slave = drain side, master = PE / global buffer side.
// Signals: POUT_rdy/POUT_ack/i_Psum/i_drconf (vector in),
//          GB_rdy/GB_ack/o_Out/o_last (beat out).
interface psum_drain_if #(
  parameter int OUTN = 4
);
  import psum_drain_pkg::*;

  logic                          POUT_rdy;
  logic                          POUT_ack;
  logic [PEROW-1:0][PSUMDWD-1:0] i_Psum;
  DRconf                         i_drconf;
  logic                          GB_rdy;
  logic                          GB_ack;
  logic [OUTN-1:0][DWD-1:0]      o_Out;
  logic                          o_last;

  modport slave (
    input  POUT_rdy, i_Psum, i_drconf, GB_ack,
    output POUT_ack, GB_rdy, o_Out, o_last
  );

  modport master (
    output POUT_rdy, i_Psum, i_drconf, GB_ack,
    input  POUT_ack, GB_rdy, o_Out, o_last
  );

endinterface

// File: rtl/psum_drain_quant.sv
// rtl/psum_drain_quant.sv - single-lane ReLU / rounding shift / saturation
// Purpose: combinational quantizer of one signed PSUMDWD-bit psum to DWD bits.
// Ports:   psum_i  signed psum (two's complement bits)
//          conf_i  {relu_en, shift}
//          q_o     saturated signed DWD-bit result
module psum_quant
  import psum_drain_pkg::*;
(
  input  logic [PSUMDWD-1:0] psum_i,
  input  DRconf              conf_i,
  output logic [DWD-1:0]     q_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int XW = PSUMDWD + 1;
  localparam logic [DRSHIFTWD-1:0] SHIFT_CAP = DRSHIFTWD'(PSUMDWD);
  localparam logic signed [XW-1:0] QMAX = XW'((2 ** (DWD - 1)) - 1);
  localparam logic signed [XW-1:0] QMIN = XW'(-(2 ** (DWD - 1)));

  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] sum;
  logic signed [XW-1:0] shr;

  always_comb begin
    x_ext = $signed({psum_i[PSUMDWD-1], psum_i});
    if (conf_i.relu_en && psum_i[PSUMDWD-1]) begin
      x_ext = '0;
    end
    rnd = '0;
    sum = x_ext;
    shr = x_ext;
    if (conf_i.shift >= SHIFT_CAP) begin
      // Every magnitude bit is shifted out; only the sign survives.
      shr = {XW{x_ext[XW-1]}};
    end else if (conf_i.shift != '0) begin
      rnd = XW'(1) << (conf_i.shift - DRSHIFTWD'(1));
      sum = x_ext + rnd;
      shr = sum >>> conf_i.shift;
    end
    if (shr > QMAX) begin
      q_o = QMAX[DWD-1:0];
    end else if (shr < QMIN) begin
      q_o = QMIN[DWD-1:0];
    end else begin
      q_o = shr[DWD-1:0];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - PE column drain: quantize psum vectors, buffer, serialize to GB
// Purpose: accepts PEROW-lane psum vectors, quantizes them on the write path,
//          stores up to DEPTH vectors and emits each as BEATS beats of OUTN words.
// Ports:   i_clk    clock
//          i_rst    synchronous active-high reset
//          bus      psum_drain_if.slave (POUT in, GB out)
//          o_count  FIFO occupancy in vectors
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int OUTN  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  psum_drain_if.slave           bus,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int BEATS = PEROW / OUTN;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [PEROW-1:0][DWD-1:0] qvec;
  logic [PEROW-1:0][DWD-1:0] mem_q [DEPTH];
  logic [PEROW-1:0][DWD-1:0] head;
  logic [AW-1:0]             wr_q;
  logic [AW-1:0]             rd_q;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;
  logic                      ack_q;
  dr_state_e                 state_q;
  dr_state_e                 state_d;
  logic [BW-1:0]             beat_q;
  logic [BW-1:0]             beat_d;
  logic                      gb_rdy_q;
  logic                      gb_rdy_d;
  logic                      last_q;
  logic                      last_d;
  logic                      push;
  logic                      gb_xfer;
  logic                      pop;

  for (genvar l = 0; l < PEROW; l++) begin : g_lane
    psum_quant u_quant (
      .psum_i (bus.i_Psum[l]),
      .conf_i (bus.i_drconf),
      .q_o    (qvec[l])
    );
  end

  // Acceptance uses the registered ack only, so a pop never frees a slot
  // for a push in the same cycle.
  assign push    = bus.POUT_rdy && ack_q;
  assign gb_xfer = gb_rdy_q && bus.GB_ack;
  assign pop     = gb_xfer && (beat_q == LAST_BEAT);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      ack_q   <= (count_d != FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem_q[wr_q] <= qvec;
    end
  end

  // Output FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= DR_IDLE;
      beat_q   <= '0;
      gb_rdy_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      gb_rdy_q <= gb_rdy_d;
      last_q   <= last_d;
    end
  end

  // Output FSM: next state. count_d is used so a vector pushed into an
  // empty FIFO is presented the very next cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      DR_IDLE: begin
        if (count_d != '0) begin
          state_d = DR_SEND;
          beat_d  = '0;
        end
      end
      DR_SEND: begin
        if (gb_xfer) begin
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + BW'(1);
          end else begin
            beat_d = '0;
            if (count_d == '0) state_d = DR_IDLE;
          end
        end
      end
      default: state_d = DR_IDLE;
    endcase
  end

  // Output FSM: outputs, registered through the state register process.
  always_comb begin
    gb_rdy_d = (state_d == DR_SEND);
    last_d   = (state_d == DR_SEND) && (beat_d == LAST_BEAT);
  end

  // Beat data depends only on registered pointer/beat, never on GB_ack.
  always_comb begin
    head      = mem_q[rd_q];
    bus.o_Out = '0;
    if (gb_rdy_q) begin
      bus.o_Out = head[int'(beat_q) * OUTN +: OUTN];
    end
  end

  assign bus.POUT_ack = ack_q;
  assign bus.GB_rdy   = gb_rdy_q;
  assign bus.o_last   = last_q;
  assign o_count      = count_q;

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - self-checking bench for psum_drain
module tb_psum_drain;
  import psum_drain_pkg::*;

  localparam int DEPTH = 2;
  localparam int OUTN  = 4;
  localparam int BEATS = PEROW / OUTN;
  localparam int NT    = 6;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(DEPTH):0] cnt;

  psum_drain_if #(.OUTN(OUTN)) bus ();

  psum_drain #(.DEPTH(DEPTH), .OUTN(OUTN)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .bus     (bus.slave),
    .o_count (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]               id;
    logic [PEROW-1:0][DWD-1:0] lanes;
  } mvec_t;

  typedef struct packed {
    logic [PEROW-1:0][PSUMDWD-1:0] psum;
    logic                          relu;
    logic [DRSHIFTWD-1:0]          shift;
    logic [PEROW-1:0][DWD-1:0]     exp;
  } tv_t;

  mvec_t mq[$];
  int    mbeat, next_id, cyc;
  bit    last_push, last_pop;
  int    nerr, nchk;
  tv_t   tv [NT];

  function automatic void chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference quantizer: exact integer arithmetic, floor division for the shift.
  function automatic int qref(int x, bit relu, int sh);
    longint v, d, q;
    v = x;
    if (relu && v < 0) v = 0;
    if (sh >= PSUMDWD) begin
      q = (v < 0) ? -1 : 0;
    end else if (sh == 0) begin
      q = v;
    end else begin
      d = longint'(1) << sh;
      v = v + d / 2;
      q = v / d;
      if ((v % d != 0) && (v < 0)) q = q - 1;
    end
    if (q > (2 ** (DWD - 1)) - 1) q = (2 ** (DWD - 1)) - 1;
    if (q < -(2 ** (DWD - 1)))    q = -(2 ** (DWD - 1));
    return int'(q);
  endfunction

  task automatic check_outputs(bit r);
    int sz;
    sz = mq.size();
    chk("o_count", int'(cnt), sz);
    chk("POUT_ack", int'(bus.POUT_ack), (!r && sz != DEPTH) ? 1 : 0);
    chk("GB_rdy", int'(bus.GB_rdy), (sz != 0) ? 1 : 0);
    chk("o_last", int'(bus.o_last), (sz != 0 && mbeat == BEATS - 1) ? 1 : 0);
    for (int k = 0; k < OUTN; k++) begin
      if (sz != 0)
        chk("o_Out", int'($signed(bus.o_Out[k])), int'($signed(mq[0].lanes[mbeat * OUTN + k])));
      else if (r)
        chk("o_Out_rst", int'($signed(bus.o_Out[k])), 0);
    end
  endtask

  // One clock: capture the handshakes about to complete, advance the model
  // with them, then compare the DUT outputs after the edge.
  task automatic tick();
    bit    pt, gt, r;
    mvec_t nv;
    pt = bus.POUT_rdy && bus.POUT_ack;
    gt = bus.GB_rdy && bus.GB_ack;
    r  = rst;
    nv.id = 16'(next_id);
    for (int i = 0; i < PEROW; i++)
      nv.lanes[i] = DWD'(qref(int'($signed(bus.i_Psum[i])), bus.i_drconf.relu_en,
                              int'(bus.i_drconf.shift)));
    @(posedge clk);
    #1;
    cyc++;
    last_push = 0;
    last_pop  = 0;
    if (r) begin
      mq.delete();
      mbeat = 0;
    end else begin
      if (gt) begin
        if (mbeat == BEATS - 1) begin
          void'(mq.pop_front());
          mbeat    = 0;
          last_pop = 1;
        end else begin
          mbeat++;
        end
      end
      if (pt) begin
        mq.push_back(nv);
        next_id++;
        last_push = 1;
      end
    end
    check_outputs(r);
  endtask

  task automatic drive_rand();
    for (int i = 0; i < PEROW; i++)
      bus.i_Psum[i] = ($urandom_range(0, 1) == 1) ? PSUMDWD'($urandom)
                                                  : PSUMDWD'($urandom_range(0, 511) - 256);
    bus.i_drconf.relu_en = 1'($urandom_range(0, 1));
    bus.i_drconf.shift   = DRSHIFTWD'($urandom_range(0, 18));
  endtask

  task automatic wait_push(string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_push && n < 20);
    chk(name, int'(last_push), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.POUT_rdy = 0;
    bus.GB_ack   = 1;
    while (mq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", mq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1);
  end

  initial begin
    int acc, n, pop_c, acc_c;
    nerr = 0; nchk = 0; cyc = 0; mbeat = 0; next_id = 0;
    rst = 1;
    bus.POUT_rdy = 0;
    bus.GB_ack   = 0;
    bus.i_Psum   = '0;
    bus.i_drconf = '0;

    for (int e = 0; e < NT; e++) tv[e] = '0;
    for (int i = 0; i < PEROW; i++) tv[0].psum[i] = PSUMDWD'(i * 10);
    tv[0].shift = 2;
    tv[0].exp   = {8'd38, 8'd35, 8'd33, 8'd30, 8'd28, 8'd25, 8'd23, 8'd20,
                   8'd18, 8'd15, 8'd13, 8'd10, 8'd8,  8'd5,  8'd3,  8'd0};
    tv[1].psum[0] = 16'h7FFF; tv[1].psum[1] = 16'h8000;
    tv[1].psum[2] = 16'hFFFB; tv[1].psum[3] = 16'h0006;
    tv[1].relu = 1;
    tv[1].exp[0] = 8'h7F; tv[1].exp[3] = 8'h06;
    tv[2].psum = tv[1].psum;
    tv[2].exp[0] = 8'h7F; tv[2].exp[1] = 8'h80; tv[2].exp[2] = 8'hFB; tv[2].exp[3] = 8'h06;
    tv[3].shift = 2;
    tv[3].psum[0] = 16'd6;    tv[3].psum[1] = 16'hFFFA; tv[3].psum[2] = 16'd2;
    tv[3].psum[3] = 16'hFFFE; tv[3].psum[4] = 16'h7FFF; tv[3].psum[5] = 16'h8000;
    tv[3].exp[0] = 8'd2; tv[3].exp[1] = 8'hFF; tv[3].exp[2] = 8'd1;
    tv[3].exp[3] = 8'd0; tv[3].exp[4] = 8'h7F; tv[3].exp[5] = 8'h80;
    tv[4].shift = 20;
    tv[4].psum[0] = 16'd1000; tv[4].psum[1] = 16'hFFFB;
    tv[4].psum[2] = 16'h7FFF; tv[4].psum[3] = 16'h8000;
    tv[4].exp[1] = 8'hFF; tv[4].exp[3] = 8'hFF;
    tv[5].shift = 1;
    tv[5].psum[0] = 16'd3;   tv[5].psum[1] = 16'hFFFD; tv[5].psum[2] = 16'd1;
    tv[5].psum[3] = 16'hFFFF; tv[5].psum[4] = 16'd255; tv[5].psum[5] = 16'hFF00;
    tv[5].exp[0] = 8'd2; tv[5].exp[1] = 8'hFF; tv[5].exp[2] = 8'd1;
    tv[5].exp[3] = 8'd0; tv[5].exp[4] = 8'h7F; tv[5].exp[5] = 8'h80;

    repeat (3) tick();
    chk("rst_ack_low", int'(bus.POUT_ack), 0);
    rst = 0;
    tick();
    chk("ack_after_rst", int'(bus.POUT_ack), 1);

    // Table vectors: one at a time with GB_ack held high.
    for (int e = 0; e < NT; e++) begin
      bus.i_Psum           = tv[e].psum;
      bus.i_drconf.relu_en = tv[e].relu;
      bus.i_drconf.shift   = tv[e].shift;
      bus.POUT_rdy = 1;
      bus.GB_ack   = 1;
      wait_push("tbl_push");
      bus.POUT_rdy = 0;
      for (int b = 0; b < BEATS; b++) begin
        chk("tbl_gb_rdy", int'(bus.GB_rdy), 1);
        chk("tbl_last", int'(bus.o_last), (b == BEATS - 1) ? 1 : 0);
        for (int k = 0; k < OUTN; k++)
          chk("tbl_lane", int'($signed(bus.o_Out[k])), int'($signed(tv[e].exp[b * OUTN + k])));
        tick();
      end
      chk("tbl_idle_rdy", int'(bus.GB_rdy), 0);
      chk("tbl_idle_count", int'(cnt), 0);
    end

    // Backpressure: fill the FIFO, then check release timing.
    bus.GB_ack   = 0;
    bus.POUT_rdy = 1;
    acc = 0; n = 0;
    while (acc < 2 && n < 20) begin
      drive_rand();
      tick();
      if (last_push) acc++;
      n++;
    end
    chk("bp_two_accepted", acc, 2);
    drive_rand();
    repeat (3) tick();
    chk("bp_ack_low", int'(bus.POUT_ack), 0);
    chk("bp_count", int'(cnt), 2);
    bus.GB_ack = 1;
    pop_c = -1; acc_c = -1; n = 0;
    while (acc_c < 0 && n < 20) begin
      tick();
      if (last_pop && pop_c < 0) pop_c = cyc;
      if (last_push) acc_c = cyc;
      n++;
    end
    chk("bp_accept_delay", acc_c - pop_c, 1);
    drain();

    // Push and pop in the same cycle at count 1.
    bus.GB_ack = 1;
    drive_rand();
    bus.POUT_rdy = 1;
    wait_push("pp_push_a");
    bus.POUT_rdy = 0;
    n = 0;
    while (mbeat != BEATS - 1 && n < 10) begin
      tick();
      n++;
    end
    drive_rand();
    bus.POUT_rdy = 1;
    tick();
    chk("pp_both", int'(last_push && last_pop), 1);
    chk("pp_count", int'(cnt), 1);
    drain();

    // Reset during beat 2 of a vector.
    drive_rand();
    bus.POUT_rdy = 1;
    wait_push("rst_push");
    bus.POUT_rdy = 0;
    tick();
    tick();
    rst = 1;
    tick();
    chk("rst_mid_gb_rdy", int'(bus.GB_rdy), 0);
    chk("rst_mid_count", int'(cnt), 0);
    chk("rst_mid_ack", int'(bus.POUT_ack), 0);
    rst = 0;
    tick();
    drive_rand();
    bus.POUT_rdy = 1;
    wait_push("post_rst_push");
    bus.POUT_rdy = 0;
    chk("post_rst_rdy", int'(bus.GB_rdy), 1);
    chk("post_rst_last", int'(bus.o_last), 0);
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive_rand();
      bus.POUT_rdy = ($urandom_range(0, 2) != 0);
      bus.GB_ack   = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
# psum_drain

Downstream drain stage of the PE array column. Consumes the PEROW partial sums a PE emits on its POUT handshake and applies optional ReLU, round-to-nearest right shift and saturation to DWD bits. Results are buffered in a small FIFO and serialized in OUTN-word beats toward the global buffer write port. It decouples PE pipeline stalls from global-buffer arbitration.

## Interface
- DEPTH, 2, FIFO entries (each holds one full PEROW-lane psum vector, already quantized); power of two, ≥2
- OUTN, 4, output words per beat; PEROW % OUTN == 0; BEATS = PEROW/OUTN
- PEROW, DWD, PSUMDWD: taken from PECfg, not module parameters
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset; synchronous, active-high
- POUT_rdy  in  1  upstream psum vector valid
- POUT_ack  out  1  drain accepts vector; transfer when POUT_rdy && POUT_ack
- i_Psum  in  PSUMDWD × [PEROW]  signed psums from PE
- i_drconf  in  DRconf  {relu_en 1b, shift 5b}; sampled on each POUT transfer
- GB_rdy  out  1  output beat valid
- GB_ack  in  1  global buffer accepts beat; transfer when GB_rdy && GB_ack
- o_Out  out  DWD × [OUTN]  quantized signed words of current beat; lane k of beat b = psum lane b*OUTN+k
- o_last  out  1  current beat is the last (b == BEATS-1) of its vector
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy in vectors

## Operation
- Quantize per lane at write time: x = i_Psum; if relu_en and x<0, x=0; if shift>0, x = (x + 2^(shift-1)) >>> shift, addition done in PSUMDWD+1 bits (no wrap); saturate to [-2^(DWD-1), 2^(DWD-1)-1]. shift ≥ PSUMDWD yields 0 after rounding (or -1 for negative inputs without ReLU, the result of the arithmetic shift).
- FIFO: write pointer advances on POUT transfer, read pointer on final-beat GB transfer; pointers wrap modulo DEPTH; count = writes − reads.
- POUT_ack = (count != DEPTH), driven from registered state only; no push-through when full, even if a pop occurs the same cycle.
- Output FSM, two states:
  - IDLE: GB_rdy=0; move to SEND when count>0.
  - SEND: GB_rdy=1, o_Out = head vector lanes [beat*OUTN +: OUTN]. On GB transfer: if beat<BEATS-1, beat++; else beat=0, pop; stay in SEND if count after the pop >0, else go to IDLE.
- Simultaneous push and pop in one cycle: count unchanged; both pointers advance.
- While GB_rdy && !GB_ack: o_Out, o_last and GB_rdy hold stable.
- Reset mid-operation discards all buffered vectors and any partially sent vector; no resume.

## Timing
- Reset values: POUT_ack=0 during reset and 1 the first cycle after; GB_rdy=0, o_last=0, o_Out all 0, o_count=0, beat=0, pointers 0.
- Latency: vector accepted in cycle t (empty FIFO) -> GB_rdy=1 with beat 0 in cycle t+1.
- Throughput: one beat per cycle under continuous GB_ack; a vector takes BEATS cycles; sustained full rate when POUT arrives no faster than every BEATS cycles.
- Registered outputs: GB_rdy, o_last, o_count, POUT_ack. o_Out is a mux from FIFO storage on registered head pointer and beat count, with no path from GB_ack.
- Space freed by a pop becomes visible on POUT_ack the cycle after.

## Structure
- PECfg additions: typedef struct packed DRconf {logic relu_en; logic [4:0] shift;}. Constant DRSHIFTWD=5.
- Sub-module psum_quant: combinational single-lane ReLU/round/shift/saturate, generated PEROW times on the write path.
- FIFO storage is a flat register array inside psum_drain; the RF_2P macro is not used, because the read needs a wide OUTN-lane slice mux.

## Test plan
Defaults: DWD=8, PSUMDWD=16, PEROW=16, OUTN=4, DEPTH=2.
- Single vector, lanes=i*10, shift=2, relu off, GB_ack=1 -> 4 beats in cycles t+1..t+4: first beat {0,3,5,8}, o_last only on 4th beat, then IDLE with o_count=0.
- Saturation/ReLU: psums {32767, -32768, -5, 6} with shift=0, relu=1 -> {127,0,0,6}; same with relu=0 -> {127,-128,-5,6}.
- Rounding: psum 6 and -6 with shift=2 -> 2 and -1; psum 1000 with shift=20 -> 0.
- Backpressure: hold GB_ack=0, push 3 vectors -> POUT_ack drops after the 2nd acceptance, o_count=2, o_Out stable; release GB_ack -> 3rd vector accepted the cycle after the 1st vector's last beat pops.
- Simultaneous push/pop at count=1 -> o_count stays 1 and ordering is preserved (vector IDs checked by scoreboard).
- Assert i_rst during beat 2 of a vector -> next cycle GB_rdy=0, o_count=0, POUT_ack=0; after release a new vector starts at beat 0.
